fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of l1_cache.
- Owns the program counter and drives the cache's read_addr and clk_en.
- Captures read_data when data_ready is high and hands instruction words to decode through a valid/ready handshake.
- Handles redirects from execute and stalls from decode without dropping or duplicating words.

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of l1_cache.
// Owns the PC, issues one cache read at a time, and delivers words to decode
// over a valid/ready handshake. A one-entry skid buffer absorbs the single
// response that can land while decode is stalled.
// Optional build macro: JUMP_PREDECODE_EN (local redirect on J-type words).
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(10)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_en,
    input  logic [31:0]       cache_data,
    input  logic              cache_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       skid_data_q, skid_data_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              skid_valid_q, skid_valid_d;

    logic issue;     // cache samples cache_addr at this edge
    logic reissue;   // outstanding read not answered yet: repeat same address
    logic resp;      // outstanding read answered this cycle
    logic out_free;  // output register empty or being drained this edge

    // Issue decision and cache-facing outputs
    always_comb begin
        issue    = !rst && !redirect_valid && !skid_valid_q
                   && !(inflight_q && instr_valid_q && !instr_ready);
        reissue  = inflight_q && !cache_ready;
        resp     = inflight_q && cache_ready;
        out_free = !instr_valid_q || instr_ready;
        cache_en   = issue;
        cache_addr = reissue ? inflight_pc_q : pc_q;
    end

    // Next-state: issue bookkeeping, response steering, drain, redirect
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        skid_data_d   = skid_data_q;
        skid_pc_d     = skid_pc_q;
        skid_valid_d  = skid_valid_q;

        // A stalled read is repeated without touching pc; a fresh issue
        // keeps inflight set even when the previous response lands now.
        if (issue) begin
            if (!reissue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + ADDR_W'(1);
            end
        end else if (resp) begin
            inflight_d = 1'b0;
        end

        // Program order: skid entry is older than any response arriving now.
        if (out_free) begin
            if (skid_valid_q) begin
                instr_d       = skid_data_q;
                instr_pc_d    = skid_pc_q;
                instr_valid_d = 1'b1;
                skid_valid_d  = 1'b0;
                if (resp) begin
                    skid_data_d  = cache_data;
                    skid_pc_d    = inflight_pc_q;
                    skid_valid_d = 1'b1;
                end
            end else if (resp) begin
                instr_d       = cache_data;
                instr_pc_d    = inflight_pc_q;
                instr_valid_d = 1'b1;
            end else begin
                instr_valid_d = 1'b0;
            end
        end else if (resp) begin
            skid_data_d  = cache_data;
            skid_pc_d    = inflight_pc_q;
            skid_valid_d = 1'b1;
        end

`ifdef JUMP_PREDECODE_EN
        // Jump word is still delivered; the fall-through read issued at this
        // edge is squashed by dropping inflight, so its data is ignored.
        if (resp && (cache_data[31:26] == 6'b000010)) begin
            logic [31:0] jump_off;
            jump_off   = {{6{cache_data[25]}}, cache_data[25:0]};
            pc_d       = inflight_pc_q + jump_off[ADDR_W-1:0];
            inflight_d = 1'b0;
        end
`endif

        // External redirect wins over everything except reset; a transfer at
        // this edge still completes from decode's point of view.
        if (redirect_valid) begin
            pc_d          = redirect_addr;
            inflight_d    = 1'b0;
            skid_valid_d  = 1'b0;
            instr_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            skid_data_q   <= '0;
            skid_pc_q     <= '0;
            skid_valid_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            skid_data_q   <= skid_data_d;
            skid_pc_q     <= skid_pc_d;
            skid_valid_q  <= skid_valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a registered cache model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] cache_addr;
    logic        cache_en;
    logic [31:0] cache_data;
    logic        cache_ready;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int          total;
    int          bad;
    logic        jump_test;
    logic [15:0] cache_addr_q;
    logic [15:0] got_pc[$];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .cache_addr     (cache_addr),
        .cache_en       (cache_en),
        .cache_data     (cache_data),
        .cache_ready    (cache_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: tagged address words, plus a backward jump at 15 when enabled
    function automatic logic [31:0] word_at(input logic [15:0] a);
        if (jump_test && a == 16'd15)
            return {6'b000010, 26'h3FFFFFB};
        return {16'h5A5A, a};
    endfunction

    // Cache registers the address when enabled; data shown only when ready
    always @(posedge clk) begin
        if (cache_en)
            cache_addr_q <= cache_addr;
    end
    assign cache_data = cache_ready ? word_at(cache_addr_q) : 32'hBAD0_BAD0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, settle, log any transfer
    task automatic cyc(input logic r, input logic rdy, input logic crdy,
                       input logic rv, input logic [15:0] ra);
        @(negedge clk);
        rst            = r;
        instr_ready    = rdy;
        cache_ready    = crdy;
        redirect_valid = rv;
        redirect_addr  = ra;
        #1;
        if (!rst && instr_valid && instr_ready) begin
            got_pc.push_back(instr_pc);
            $display("xfer pc=%h instr=%h", instr_pc, instr);
            check_eq("xfer_data", instr, word_at(instr_pc));
        end
    endtask

    logic [15:0] exp_s4 [5];
    logic [15:0] exp_s5 [3];

    initial begin
        total = 0;
        bad   = 0;
        jump_test      = 1'b0;
        rst            = 1'b1;
        instr_ready    = 1'b1;
        cache_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        exp_s4 = '{16'd10, 16'd11, 16'd40, 16'd41, 16'd42};
        exp_s5 = '{16'hFFFE, 16'hFFFF, 16'h0000};

        // Reset state
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        check_eq("rst_cache_en", 32'(cache_en), 0);
        check_eq("rst_valid", 32'(instr_valid), 0);
        check_eq("rst_instr_pc", 32'(instr_pc), 0);
        check_eq("rst_instr", instr, 0);

        // Streaming from reset, then a 5-cycle decode stall
        got_pc.delete();
        cyc(0, 1, 1, 0, 0);
        check_eq("s1_c0_en", 32'(cache_en), 1);
        check_eq("s1_c0_addr", 32'(cache_addr), 10);
        check_eq("s1_c0_valid", 32'(instr_valid), 0);
        cyc(0, 1, 1, 0, 0);
        check_eq("s1_c1_addr", 32'(cache_addr), 11);
        check_eq("s1_c1_valid", 32'(instr_valid), 0);
        cyc(0, 1, 1, 0, 0);
        check_eq("s1_c2_valid", 32'(instr_valid), 1);
        check_eq("s1_c2_pc", 32'(instr_pc), 10);
        check_eq("s1_c2_addr", 32'(cache_addr), 12);
        cyc(0, 1, 1, 0, 0);
        check_eq("s1_c3_pc", 32'(instr_pc), 11);
        cyc(0, 1, 1, 0, 0);
        check_eq("s1_c4_pc", 32'(instr_pc), 12);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0, 0);
            check_eq("s2_hold_pc", 32'(instr_pc), 13);
            check_eq("s2_hold_instr", instr, word_at(16'd13));
            check_eq("s2_hold_valid", 32'(instr_valid), 1);
            check_eq("s2_hold_en", 32'(cache_en), 0);
        end
        cyc(0, 1, 1, 0, 0);
        check_eq("s2_rel_pc", 32'(instr_pc), 13);
        check_eq("s2_rel_en", 32'(cache_en), 0);
        cyc(0, 1, 1, 0, 0);
        check_eq("s2_skid_pc", 32'(instr_pc), 14);
        check_eq("s2_skid_en", 32'(cache_en), 1);
        check_eq("s2_skid_addr", 32'(cache_addr), 15);
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0);
        check_eq("s2_count", 32'(got_pc.size()), 10);
        for (int i = 0; i < 10; i++)
            check_eq("s2_order", 32'(got_pc[i]), 32'(10 + i));

        // Cache not ready for 3 cycles after reset
        cyc(1, 1, 1, 0, 0);
        got_pc.delete();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            check_eq("s3_wait_en", 32'(cache_en), 1);
            check_eq("s3_wait_addr", 32'(cache_addr), 10);
            check_eq("s3_wait_valid", 32'(instr_valid), 0);
        end
        cyc(0, 1, 1, 0, 0);
        check_eq("s3_ready_addr", 32'(cache_addr), 11);
        check_eq("s3_ready_valid", 32'(instr_valid), 0);
        cyc(0, 1, 1, 0, 0);
        check_eq("s3_first_valid", 32'(instr_valid), 1);
        check_eq("s3_first_pc", 32'(instr_pc), 10);

        // Redirect while output stalled and skid full
        cyc(1, 1, 1, 0, 0);
        got_pc.delete();
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check_eq("s4_stall_pc", 32'(instr_pc), 12);
        cyc(0, 0, 1, 1, 16'd40);
        check_eq("s4_redir_en", 32'(cache_en), 0);
        cyc(0, 1, 1, 0, 0);
        check_eq("s4_after_valid", 32'(instr_valid), 0);
        check_eq("s4_after_en", 32'(cache_en), 1);
        check_eq("s4_after_addr", 32'(cache_addr), 40);
        cyc(0, 1, 1, 0, 0);
        check_eq("s4_gap_valid", 32'(instr_valid), 0);
        cyc(0, 1, 1, 0, 0);
        check_eq("s4_target_pc", 32'(instr_pc), 40);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check_eq("s4_count", 32'(got_pc.size()), 5);
        for (int i = 0; i < 5; i++)
            check_eq("s4_order", 32'(got_pc[i]), 32'(exp_s4[i]));

        // PC wrap at the top of the address space
        cyc(1, 1, 1, 0, 0);
        got_pc.delete();
        cyc(0, 1, 1, 1, 16'hFFFE);
        check_eq("s5_redir_en", 32'(cache_en), 0);
        cyc(0, 1, 1, 0, 0);
        check_eq("s5_addr0", 32'(cache_addr), 32'hFFFE);
        cyc(0, 1, 1, 0, 0);
        check_eq("s5_addr1", 32'(cache_addr), 32'hFFFF);
        cyc(0, 1, 1, 0, 0);
        check_eq("s5_addr2", 32'(cache_addr), 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check_eq("s5_count", 32'(got_pc.size()), 3);
        for (int i = 0; i < 3; i++)
            check_eq("s5_order", 32'(got_pc[i]), 32'(exp_s5[i]));

        // Backward jump word at 15
        jump_test = 1'b1;
        cyc(1, 1, 1, 0, 0);
        got_pc.delete();
        for (int i = 0; i < 11; i++) cyc(0, 1, 1, 0, 0);
        check_eq("s6_count_ge7", 32'(got_pc.size() >= 7), 1);
        for (int i = 0; i < 6; i++)
            check_eq("s6_order", 32'(got_pc[i]), 32'(10 + i));
`ifdef JUMP_PREDECODE_EN
        check_eq("s6_after_jump", 32'(got_pc[6]), 10);
`else
        check_eq("s6_after_jump", 32'(got_pc[6]), 16);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
